// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: ALU op codes, FSM states
// and small decode helpers used by both the stage and its load aligner.
package mem_access_pkg;

  // Non-memory ALU codes (only the subset this stage needs to name).
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_LUI = 6'd2;

  // Memory op codes.
  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_WAIT = 2'd2,
    MA_DONE = 2'd3
  } ma_state_e;

  function automatic logic is_load(input logic [5:0] code);
    return code inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] code);
    return code inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic logic is_mem(input logic [5:0] code);
    return is_load(code) || is_store(code);
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
  function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] a);
    case (code)
      ALU_LH, ALU_LHU, ALU_SH: return a[0];
      ALU_LW, ALU_SW:          return a != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Combinational load aligner: shifts the addressed byte/halfword of the
// returned word down to bit 0 and sign- or zero-extends it per load type.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [5:0]  i_alucode,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  // Select width and extension for the load type; LW passes the word through.
  always_comb begin
    case (i_alucode)
      ALU_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      ALU_LBU: o_data = {24'h0, w_shifted[7:0]};
      ALU_LH:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      ALU_LHU: o_data = {16'h0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: performs loads/stores over a req/rvalid
// handshake, reports misalignment and bus timeouts, and passes non-memory
// ALU results straight through. Upstream is stalled outside IDLE.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  alucode,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  mem_access_if.master dmem,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  rd_out,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  ma_state_e   r_state;
  ma_state_e   w_next;
  logic [5:0]  r_alucode;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [4:0]  r_rd;
  logic [31:0] r_out_data;
  logic        r_misaligned;
  logic        r_bus_err;
  logic [7:0]  r_cnt;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  mem_access_load_align u_load_align (
    .i_rdata   (dmem.dmem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_alucode (r_alucode),
    .o_data    (w_load_data)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MA_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: route each accepted op and resolve completion or timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned
    // (which would infer a latch).
    w_next = r_state;
    case (r_state)
      MA_IDLE: if (in_valid) begin
        if (!is_mem(alucode) || is_misaligned(alucode, alu_result[1:0])) w_next = MA_DONE;
        else                                                             w_next = MA_REQ;
      end
      MA_REQ:  w_next = dmem.dmem_rvalid ? MA_DONE : MA_WAIT;
      MA_WAIT: if (dmem.dmem_rvalid || r_cnt == LP_CNT_LAST) w_next = MA_DONE;
      MA_DONE: w_next = MA_IDLE;
      default: w_next = MA_IDLE;
    endcase
  end

  // Store lane enables and replicated write data from the latched op.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_sdata;
    case (r_alucode)
      ALU_SB: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_sdata[7:0]}};
      end
      ALU_SH: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; bus fields are driven only during REQ.
  always_comb begin
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_be    = '0;
    dmem.dmem_wdata = '0;
    case (r_state)
      MA_IDLE: in_ready = 1'b1;
      MA_REQ: begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = is_store(r_alucode);
        dmem.dmem_addr  = {r_addr[31:2], 2'b00};
        dmem.dmem_be    = w_be;
        dmem.dmem_wdata = w_wdata;
      end
      MA_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Wait-cycle counter: cleared in REQ, advanced once per WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (r_state == MA_REQ) r_cnt <= '0;
    else if (r_state == MA_WAIT) r_cnt <= r_cnt + 8'd1;
  end

  // Latch the op on accept and register the result on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alucode    <= '0;
      r_addr       <= '0;
      r_sdata      <= '0;
      r_rd         <= '0;
      r_out_data   <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        MA_IDLE: if (in_valid) begin
          r_alucode <= alucode;
          r_addr    <= alu_result;
          r_sdata   <= store_data;
          r_rd      <= rd_in;
          r_bus_err <= 1'b0;
          if (!is_mem(alucode)) begin
            r_out_data   <= alu_result;
            r_misaligned <= 1'b0;
          end else begin
            r_out_data   <= '0;
            r_misaligned <= is_misaligned(alucode, alu_result[1:0]);
          end
        end
        MA_REQ, MA_WAIT: begin
          // A response in the final wait cycle takes priority over the timeout.
          if (dmem.dmem_rvalid)
            r_out_data <= is_load(r_alucode) ? w_load_data : '0;
          else if (r_state == MA_WAIT && r_cnt == LP_CNT_LAST)
            r_bus_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign rd_out     = r_rd;
  assign misaligned = r_misaligned;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed ops against a behavioural
// model of byte lanes, extension and cycle timing, plus literal expectations.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alucode;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  rd_out;
  logic        misaligned;
  logic        bus_err;

  mem_access_if dmem ();

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucode    (alucode),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_in      (rd_in),
    .dmem       (dmem.master),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .rd_out     (rd_out),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Cycle index, advanced on every rising edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model expectations for the op in flight.
  logic        exp_active = 1'b0;
  int          exp_acc;      // first cycle after the accepting edge
  int          exp_lat;      // in_valid cycle to out_valid cycle, both counted
  logic        exp_has_req;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  logic [31:0] exp_data;
  logic        exp_mis;
  logic        exp_err;
  logic [4:0]  exp_rd;

  // What the monitor observed for the current op.
  int          seen_out_cyc;
  logic [31:0] seen_data;
  logic        seen_req;
  logic        seen_we;
  logic [31:0] seen_addr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;

  // Behavioural model: nwait = cycles from request to response, <0 = never.
  task automatic set_model(input logic [5:0] code, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input logic [4:0] rd, input int nwait);
    int size, off;
    logic ld, st, tmo;
    longint v, half;
    ld   = code inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    st   = code inside {ALU_SB, ALU_SH, ALU_SW};
    size = (code inside {ALU_LB, ALU_LBU, ALU_SB}) ? 1 :
           (code inside {ALU_LH, ALU_LHU, ALU_SH}) ? 2 : 4;
    off  = int'(addr[1:0]);
    exp_rd      = rd;
    exp_mis     = (ld || st) && (off % size != 0);
    exp_has_req = (ld || st) && !exp_mis;
    tmo         = exp_has_req && (nwait < 0 || nwait > TMO);
    exp_err     = tmo;
    exp_lat     = !exp_has_req ? 2 : (tmo ? 3 + TMO : 3 + nwait);
    exp_we      = st;
    exp_addr    = addr & ~32'h3;
    exp_be      = '0;
    exp_wdata   = '0;
    for (int i = 0; i < 4; i++) begin
      if (!st || (i >= off && i < off + size)) exp_be[i] = 1'b1;
      exp_wdata[8*i +: 8] = sdata[8*(i % size) +: 8];
    end
    if (!(ld || st))            exp_data = addr;
    else if (exp_mis || st || tmo) exp_data = '0;
    else begin
      v    = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
      half = longint'(1) << (8 * size - 1);
      if ((code == ALU_LB || code == ALU_LH) && v >= half) v = v - 2 * half;
      exp_data = v[31:0];
    end
  endtask

  // Compare process: every cycle, checked away from the rising edge.
  always @(negedge clk) begin
    logic want_busy, want_out, want_req;
    want_busy = exp_active && cyc >= exp_acc && cyc <= exp_acc + exp_lat - 2;
    want_out  = exp_active && cyc == exp_acc + exp_lat - 2;
    want_req  = exp_active && exp_has_req && cyc == exp_acc;
    check("in_ready", in_ready, !want_busy);
    check("out_valid", out_valid, want_out);
    check("dmem_req", dmem.dmem_req, want_req);
    if (out_valid) begin
      seen_out_cyc = cyc;
      seen_data    = out_data;
    end
    if (want_out && out_valid) begin
      check("out_data", out_data, exp_data);
      check("rd_out", rd_out, exp_rd);
      check("misaligned", misaligned, exp_mis);
      check("bus_err", bus_err, exp_err);
    end
    if (dmem.dmem_req) begin
      seen_req   = 1'b1;
      seen_we    = dmem.dmem_we;
      seen_addr  = dmem.dmem_addr;
      seen_be    = dmem.dmem_be;
      seen_wdata = dmem.dmem_wdata;
    end
    if (want_req && dmem.dmem_req) begin
      check("dmem_we", dmem.dmem_we, exp_we);
      check("dmem_addr", dmem.dmem_addr, exp_addr);
      check("dmem_be", dmem.dmem_be, exp_be);
      if (exp_we) check("dmem_wdata", dmem.dmem_wdata, exp_wdata);
    end
  end

  // Drive one op from a falling edge and play the memory's response.
  task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int nwait,
                        input logic [31:0] lit_data, input int lit_lat);
    set_model(code, addr, sdata, rdata, rd, nwait);
    check({tag, " model_data"}, exp_data, lit_data);
    seen_out_cyc = -1;
    seen_req     = 1'b0;
    exp_acc      = cyc + 1;
    exp_active   = 1'b1;
    alucode      = code;
    alu_result   = addr;
    store_data   = sdata;
    rd_in        = rd;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    alucode    = ALU_SUB;
    alu_result = 32'hFFFF_FFFF;
    for (int k = 0; k < exp_lat - 1; k++) begin
      dmem.dmem_rvalid = exp_has_req && nwait >= 0 && k == nwait;
      dmem.dmem_rdata  = dmem.dmem_rvalid ? rdata : 32'hA5A5_A5A5;
      @(negedge clk);
    end
    dmem.dmem_rvalid = 1'b0;
    exp_active       = 1'b0;
    check({tag, " data"}, seen_data, lit_data);
    check({tag, " latency"}, seen_out_cyc - exp_acc + 2, lit_lat);
  endtask

  initial begin
    in_valid         = 1'b0;
    alucode          = '0;
    alu_result       = '0;
    store_data       = '0;
    rd_in            = '0;
    dmem.dmem_rvalid = 1'b0;
    dmem.dmem_rdata  = '0;
    seen_data        = '0;
    rst_n            = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst dmem_req", dmem.dmem_req, 0);
    check("rst dmem_we", dmem.dmem_we, 0);
    check("rst dmem_addr", dmem.dmem_addr, 0);
    check("rst dmem_be", dmem.dmem_be, 0);
    check("rst dmem_wdata", dmem.dmem_wdata, 0);
    check("rst out_data", out_data, 0);
    check("rst rd_out", rd_out, 0);
    check("rst misaligned", misaligned, 0);
    check("rst bus_err", bus_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("lb", ALU_LB, 32'h1003, 32'h0, 5'd1, 32'h80FF_1234, 0, 32'hFFFF_FF80, 3);
    check("lb req_addr", seen_addr, 32'h1000);
    check("lb req_be", seen_be, 4'hF);
    check("lb req_we", seen_we, 0);

    run_op("lhu", ALU_LHU, 32'h2002, 32'h0, 5'd2, 32'hBEEF_0000, 2, 32'h0000_BEEF, 5);

    run_op("sb", ALU_SB, 32'h3001, 32'h0000_00AB, 5'd3, 32'h0, 0, 32'h0, 3);
    check("sb req_we", seen_we, 1);
    check("sb req_be", seen_be, 4'b0010);
    check("sb req_wdata", seen_wdata, 32'hABAB_ABAB);

    run_op("lw_mis", ALU_LW, 32'h4002, 32'h0, 5'd4, 32'h0, 0, 32'h0, 2);
    check("lw_mis no_req", seen_req, 0);

    run_op("add", ALU_ADD, 32'h55, 32'h0, 5'd5, 32'h0, 0, 32'h55, 2);

    run_op("lw_tmo", ALU_LW, 32'h5000, 32'h0, 5'd6, 32'h0, -1, 32'h0, 3 + TMO);

    run_op("lh", ALU_LH, 32'h6002, 32'h0, 5'd7, 32'h8001_7FFF, 1, 32'hFFFF_8001, 4);
    run_op("lbu", ALU_LBU, 32'h7002, 32'h0, 5'd8, 32'h00F2_3456, 0, 32'h0000_00F2, 3);

    run_op("sh", ALU_SH, 32'h8002, 32'h1234_CAFE, 5'd9, 32'h0, 3, 32'h0, 6);
    check("sh req_be", seen_be, 4'b1100);
    check("sh req_wdata", seen_wdata, 32'hCAFE_CAFE);

    run_op("sw", ALU_SW, 32'h9000, 32'hDEAD_BEEF, 5'd10, 32'h0, 0, 32'h0, 3);
    run_op("sh_mis", ALU_SH, 32'h8001, 32'h1234_5678, 5'd11, 32'h0, 0, 32'h0, 2);

    // Response arriving in the very last wait cycle beats the timeout.
    run_op("lw_last", ALU_LW, 32'hA004, 32'h0, 5'd12, 32'h1234_5678, TMO, 32'h1234_5678, 3 + TMO);

    run_op("sb_lane3", ALU_SB, 32'hB003, 32'h0000_005A, 5'd13, 32'h0, 0, 32'h0, 3);
    check("sb_lane3 req_be", seen_be, 4'b1000);
    check("sb_lane3 req_wdata", seen_wdata, 32'h5A5A_5A5A);

    // Reset while waiting, then stray responses in IDLE must be ignored.
    set_model(ALU_LW, 32'hC000, 32'h0, 32'h0, 5'd14, -1);
    exp_acc    = cyc + 1;
    exp_active = 1'b1;
    alucode    = ALU_LW;
    alu_result = 32'hC000;
    rd_in      = 5'd14;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n      = 1'b0;
    exp_active = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dmem.dmem_rvalid = 1'b1;
      dmem.dmem_rdata  = 32'h1111_2222;
      @(negedge clk);
    end
    dmem.dmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst in_ready", in_ready, 1);
    check("post_rst out_valid", out_valid, 0);
    check("post_rst out_data", out_data, 0);

    run_op("add_after_rst", ALU_ADD, 32'h0000_1234, 32'h0, 5'd15, 32'h0, 0, 32'h0000_1234, 2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
